// File: rtl/nand_flash_responder_if.sv
// NAND flash command/address/data bus between a controller (master) and a
// flash device model (slave). Clock and reset travel as separate ports.
interface nand_flash_responder_if;
    logic       ce_n;
    logic       cle;
    logic       ale;
    logic       we_n;
    logic       re_n;
    logic       wp_n;
    logic [7:0] dq_in;
    logic [7:0] dq_out;
    logic       dq_oe;
    logic       rb_n;

    modport master (
        output ce_n, cle, ale, we_n, re_n, wp_n, dq_in,
        input  dq_out, dq_oe, rb_n
    );

    modport slave (
        input  ce_n, cle, ale, we_n, re_n, wp_n, dq_in,
        output dq_out, dq_oe, rb_n
    );
endinterface

// File: rtl/nand_flash_responder.sv
// Cycle-based NAND flash device model: decodes command/address/data/read
// transfers, holds a page-organised byte array and a page register, models
// busy time on rb_n and returns page, ID and status data.
module nand_flash_responder #(
    parameter int         PAGE_BYTES      = 16,
    parameter int         PAGES_PER_BLOCK = 4,
    parameter int         NUM_BLOCKS      = 4,
    parameter int         TR_CYCLES       = 8,
    parameter int         TPROG_CYCLES    = 20,
    parameter int         TERS_CYCLES     = 40,
    parameter int         TRST_CYCLES     = 4,
    parameter logic [7:0] ID_MAKER        = 8'hEC,
    parameter logic [7:0] ID_DEVICE       = 8'hDA
) (
    input logic                  clk,
    input logic                  rst,
    nand_flash_responder_if.slave bus
);
    localparam int CW  = $clog2(PAGE_BYTES);
    localparam int PBW = $clog2(PAGES_PER_BLOCK);
    localparam int RW  = $clog2(PAGES_PER_BLOCK * NUM_BLOCKS);
    localparam int AW  = RW + CW;
    localparam int NB  = 1 << AW;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DIN, S_BUSY, S_DOUT} state_t;
    typedef enum logic [1:0] {M_STATUS, M_PAGE, M_ID} mode_t;
    typedef enum logic [1:0] {Q_READ, Q_PROG, Q_ERASE, Q_ID} seq_t;
    typedef enum logic [1:0] {OP_READ, OP_PROG, OP_ERASE, OP_RST} op_t;

    logic [7:0]    r_mem  [NB];
    logic [7:0]    r_page [PAGE_BYTES];
    state_t        r_state;
    mode_t         r_mode;
    seq_t          r_seq;
    op_t           r_op;
    logic [1:0]    r_acnt;
    logic [CW-1:0] r_ptr;
    logic [RW-1:0] r_row;
    logic [15:0]   r_cnt;
    logic          r_fail;
    logic          r_id_sel;
    logic [7:0]    r_dq_out;
    logic          r_dq_oe;
    logic          r_rb_n;

    logic       w_act;
    logic       w_cmd;
    logic       w_addr;
    logic       w_din;
    logic       w_rd;
    logic       w_busy;
    logic [7:0] w_status;

    // Transfer decode: simultaneous we_n/re_n or cle+ale are ignored.
    assign w_act    = ~bus.ce_n;
    assign w_cmd    = w_act & ~bus.we_n & bus.re_n &  bus.cle & ~bus.ale;
    assign w_addr   = w_act & ~bus.we_n & bus.re_n & ~bus.cle &  bus.ale;
    assign w_din    = w_act & ~bus.we_n & bus.re_n & ~bus.cle & ~bus.ale;
    assign w_rd     = w_act & ~bus.re_n & bus.we_n;
    assign w_busy   = (r_state == S_BUSY);
    assign w_status = {bus.wp_n, ~w_busy, 5'b0, r_fail};

    assign bus.dq_out = r_dq_out;
    assign bus.dq_oe  = r_dq_oe;
    assign bus.rb_n   = r_rb_n;

    // Device FSM, array, page register and registered bus outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NB; i++) r_mem[AW'(i)] <= 8'hFF;
            for (int unsigned c = 0; c < PAGE_BYTES; c++) r_page[CW'(c)] <= 8'hFF;
            r_state  <= S_IDLE;
            r_mode   <= M_STATUS;
            r_seq    <= Q_READ;
            r_op     <= OP_RST;
            r_acnt   <= '0;
            r_ptr    <= '0;
            r_row    <= '0;
            r_cnt    <= '0;
            r_fail   <= 1'b0;
            r_id_sel <= 1'b0;
            r_dq_out <= '0;
            r_dq_oe  <= 1'b0;
            r_rb_n   <= 1'b1;
        end else begin
            r_dq_oe <= 1'b0;

            // Reads are serviced by mode, independent of the command state;
            // while busy only status reads produce data.
            if (w_rd) begin
                case (r_mode)
                    M_STATUS: begin
                        r_dq_out <= w_status;
                        r_dq_oe  <= 1'b1;
                    end
                    M_ID: if (!w_busy) begin
                        r_dq_out <= r_id_sel ? ID_DEVICE : ID_MAKER;
                        r_dq_oe  <= 1'b1;
                        r_id_sel <= ~r_id_sel;
                    end
                    M_PAGE: if (!w_busy) begin
                        r_dq_out <= r_page[r_ptr];
                        r_dq_oe  <= 1'b1;
                        r_ptr    <= r_ptr + CW'(1);
                    end
                    default: ;
                endcase
            end

            if (w_cmd && bus.dq_in == 8'hFF) begin
                // Reset command aborts anything pending, including a busy op.
                r_state <= S_BUSY;
                r_op    <= OP_RST;
                r_cnt   <= 16'(TRST_CYCLES);
                r_rb_n  <= 1'b0;
                r_fail  <= 1'b0;
                r_mode  <= M_STATUS;
            end else if (w_busy) begin
                if (r_cnt == 16'd1) begin
                    r_rb_n  <= 1'b1;
                    r_state <= S_IDLE;
                    case (r_op)
                        OP_READ: begin
                            for (int unsigned c = 0; c < PAGE_BYTES; c++)
                                r_page[CW'(c)] <= r_mem[{r_row, CW'(c)}];
                            r_state <= S_DOUT;
                            r_mode  <= M_PAGE;
                        end
                        OP_PROG: begin
                            for (int unsigned c = 0; c < PAGE_BYTES; c++)
                                r_mem[{r_row, CW'(c)}] <= r_mem[{r_row, CW'(c)}] & r_page[CW'(c)];
                        end
                        OP_ERASE: begin
                            for (int unsigned i = 0; i < NB; i++)
                                if ((i >> (CW + PBW)) == (32'(r_row) >> PBW))
                                    r_mem[AW'(i)] <= 8'hFF;
                        end
                        default: ;
                    endcase
                end else begin
                    r_cnt <= r_cnt - 16'd1;
                end
                // Placed after the commit so a status request in the final
                // busy cycle still wins over the page-mode switch of a read.
                if (w_cmd && bus.dq_in == 8'h70) r_mode <= M_STATUS;
            end else if (w_cmd) begin
                case (bus.dq_in)
                    8'h00: begin
                        r_state <= S_ADDR;
                        r_seq   <= Q_READ;
                        r_acnt  <= '0;
                        r_mode  <= M_PAGE;
                    end
                    8'h30: begin
                        if (r_state == S_ADDR && r_seq == Q_READ && r_acnt == 2'd2) begin
                            r_state <= S_BUSY;
                            r_op    <= OP_READ;
                            r_cnt   <= 16'(TR_CYCLES);
                            r_rb_n  <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    8'h80: begin
                        for (int unsigned c = 0; c < PAGE_BYTES; c++) r_page[CW'(c)] <= 8'hFF;
                        r_fail  <= 1'b0;
                        r_state <= S_ADDR;
                        r_seq   <= Q_PROG;
                        r_acnt  <= '0;
                    end
                    8'h10: begin
                        r_state <= S_IDLE;
                        if (r_state == S_DIN) begin
                            if (!bus.wp_n) begin
                                r_fail <= 1'b1;
                            end else begin
                                r_state <= S_BUSY;
                                r_op    <= OP_PROG;
                                r_cnt   <= 16'(TPROG_CYCLES);
                                r_rb_n  <= 1'b0;
                            end
                        end
                    end
                    8'h60: begin
                        r_fail  <= 1'b0;
                        r_state <= S_ADDR;
                        r_seq   <= Q_ERASE;
                        r_acnt  <= '0;
                    end
                    8'hD0: begin
                        r_state <= S_IDLE;
                        if (r_state == S_ADDR && r_seq == Q_ERASE && r_acnt == 2'd1) begin
                            if (!bus.wp_n) begin
                                r_fail <= 1'b1;
                            end else begin
                                r_state <= S_BUSY;
                                r_op    <= OP_ERASE;
                                r_cnt   <= 16'(TERS_CYCLES);
                                r_rb_n  <= 1'b0;
                            end
                        end
                    end
                    8'h90: begin
                        r_state <= S_ADDR;
                        r_seq   <= Q_ID;
                        r_acnt  <= '0;
                    end
                    8'h70: begin
                        r_mode <= M_STATUS;
                        if (r_state == S_IDLE) r_state <= S_DOUT;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (w_addr && r_state == S_ADDR) begin
                case (r_seq)
                    Q_READ, Q_PROG: begin
                        if (r_acnt == 2'd0) begin
                            r_ptr  <= bus.dq_in[CW-1:0];
                            r_acnt <= 2'd1;
                        end else if (r_acnt == 2'd1) begin
                            r_row  <= bus.dq_in[RW-1:0];
                            r_acnt <= 2'd2;
                            if (r_seq == Q_PROG) r_state <= S_DIN;
                        end
                    end
                    Q_ERASE: begin
                        if (r_acnt == 2'd0) begin
                            r_row  <= bus.dq_in[RW-1:0];
                            r_acnt <= 2'd1;
                        end
                    end
                    Q_ID: begin
                        r_state  <= S_DOUT;
                        r_mode   <= M_ID;
                        r_id_sel <= 1'b0;
                    end
                    default: ;
                endcase
            end else if (w_din && r_state == S_DIN) begin
                r_page[r_ptr] <= bus.dq_in;
                r_ptr         <= r_ptr + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_nand_flash_responder.sv
// Directed bench for nand_flash_responder: stimulus pushes expected read
// bytes into a queue, a negedge monitor pops them whenever dq_oe is high.
module tb_nand_flash_responder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    nand_flash_responder_if nf_if();

    nand_flash_responder #(
        .PAGE_BYTES(16), .PAGES_PER_BLOCK(4), .NUM_BLOCKS(4),
        .TR_CYCLES(8), .TPROG_CYCLES(20), .TERS_CYCLES(40), .TRST_CYCLES(4),
        .ID_MAKER(8'hEC), .ID_DEVICE(8'hDA)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(nf_if)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every dq_oe pulse must match the oldest expectation.
    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (nf_if.dq_oe === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_dq_oe", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("read_data", 32'(nf_if.dq_out), 32'(e));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        nf_if.cle  = 1'b0;
        nf_if.ale  = 1'b0;
        nf_if.we_n = 1'b1;
        nf_if.re_n = 1'b1;
    endtask

    task automatic cmd(input logic [7:0] c);
        nf_if.cle = 1'b1; nf_if.we_n = 1'b0; nf_if.dq_in = c;
        tick(); bus_idle();
    endtask

    task automatic adr(input logic [7:0] a);
        nf_if.ale = 1'b1; nf_if.we_n = 1'b0; nf_if.dq_in = a;
        tick(); bus_idle();
    endtask

    task automatic din(input logic [7:0] d);
        nf_if.we_n = 1'b0; nf_if.dq_in = d;
        tick(); bus_idle();
    endtask

    task automatic rd(input logic [7:0] e);
        exp_q.push_back(e);
        nf_if.re_n = 1'b0;
        tick(); bus_idle();
    endtask

    // Counts cycles with rb_n low, bounded so a stuck busy cannot hang.
    task automatic busy_len(input string name, input int expn);
        int n = 0;
        while (nf_if.rb_n === 1'b0 && n < 1000) begin
            n++;
            tick();
        end
        check(name, 32'(n), 32'(expn));
    endtask

    task automatic page_read(input logic [7:0] col, input logic [7:0] row);
        cmd(8'h00); adr(col); adr(row); cmd(8'h30);
        busy_len("read_busy", 8);
    endtask

    initial begin
        rst = 1'b1;
        nf_if.ce_n = 1'b0;
        nf_if.wp_n = 1'b1;
        nf_if.dq_in = 8'h00;
        bus_idle();
        repeat (3) tick();
        check("rst_dq_out", 32'(nf_if.dq_out), 32'h0);
        check("rst_dq_oe", 32'(nf_if.dq_oe), 32'h0);
        check("rst_rb_n", 32'(nf_if.rb_n), 32'h1);
        rst = 1'b0;
        tick();

        // Read ID
        cmd(8'h90); adr(8'h00);
        rd(8'hEC); rd(8'hDA);
        check("id_rb_n", 32'(nf_if.rb_n), 32'h1);

        // Program row 5, then read back
        cmd(8'h80); adr(8'h00); adr(8'h05); din(8'hA5); din(8'h3C); cmd(8'h10);
        busy_len("prog_busy", 20);
        page_read(8'h00, 8'h05);
        rd(8'hA5); rd(8'h3C); rd(8'hFF);

        // Reprogram: bits only clear
        cmd(8'h80); adr(8'h00); adr(8'h05); din(8'h0F); cmd(8'h10);
        busy_len("reprog_busy", 20);
        page_read(8'h00, 8'h05);
        rd(8'h05); rd(8'h3C);

        // Mark row 8, erase block 1 (rows 4..7)
        cmd(8'h80); adr(8'h00); adr(8'h08); din(8'h77); cmd(8'h10);
        busy_len("prog8_busy", 20);
        cmd(8'h60); adr(8'h04); cmd(8'hD0);
        busy_len("erase_busy", 40);
        for (int r = 4; r < 8; r++) begin
            page_read(8'h00, 8'(r));
            rd(8'hFF);
            if (r == 5) repeat (15) rd(8'hFF);
        end
        page_read(8'h00, 8'h08);
        rd(8'h77); rd(8'hFF);

        // Write protect: no busy, fail set, array unchanged
        nf_if.wp_n = 1'b0;
        cmd(8'h80); adr(8'h00); adr(8'h02); din(8'h12); cmd(8'h10);
        check("wp_no_busy", 32'(nf_if.rb_n), 32'h1);
        tick();
        check("wp_no_busy_later", 32'(nf_if.rb_n), 32'h1);
        cmd(8'h70); rd(8'h41);
        nf_if.wp_n = 1'b1;
        page_read(8'h00, 8'h02);
        rd(8'hFF);

        // Column wrap on program, status during busy
        cmd(8'h80); adr(8'h0F); adr(8'h09); din(8'h11); din(8'h22); din(8'h33); cmd(8'h10);
        cmd(8'h70); rd(8'h80);
        busy_len("prog_wrap_rest", 18);
        page_read(8'h0F, 8'h09);
        rd(8'h11); rd(8'h22);
        // Status, then 00 with no address resumes page reads at the pointer
        cmd(8'h70); rd(8'hC0);
        cmd(8'h00); rd(8'h33); rd(8'hFF);

        // Reset command mid program busy aborts the program
        cmd(8'h80); adr(8'h00); adr(8'h0A); din(8'h55); cmd(8'h10);
        repeat (5) tick();
        cmd(8'hFF);
        busy_len("rst_cmd_busy", 4);
        page_read(8'h00, 8'h0A);
        rd(8'hFF);

        // Async reset mid erase: immediate ready, array back to erased
        cmd(8'h60); adr(8'h08); cmd(8'hD0);
        tick(); tick();
        rst = 1'b1;
        #1;
        check("async_rst_rb_n", 32'(nf_if.rb_n), 32'h1);
        tick();
        rst = 1'b0;
        tick();
        page_read(8'h00, 8'h08);
        rd(8'hFF);

        repeat (3) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/nand_flash_responder.md
Name: nand_flash_responder

Overview:
- Cycle-based NAND flash device model. It is the responder end of the command/address/data bus that the memory controller drives.
- It decodes CLE/ALE/WE_n/RE_n transfers, holds a small page-organised byte array, models busy time on R/B_n and returns read, ID and status data.
- It is instantiated beside the controller in the verification top and replaces a behavioural flash.

Parameters:
- PAGE_BYTES, 16: bytes per page; power of 2; column width CW = log2(PAGE_BYTES).
- PAGES_PER_BLOCK, 4: pages per block; power of 2.
- NUM_BLOCKS, 4: blocks in the array. Row width RW = log2(PAGES_PER_BLOCK*NUM_BLOCKS), at most 8.
- TR_CYCLES, 8: page-read busy cycles.
- TPROG_CYCLES, 20: program busy cycles.
- TERS_CYCLES, 40: block-erase busy cycles.
- TRST_CYCLES, 4: reset-command busy cycles.
- ID_MAKER, 8'hEC: first ID byte.
- ID_DEVICE, 8'hDA: second ID byte.

Ports:
- clk  input  1  system clock; all sampling on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ce_n  input  1  chip enable, active low; when high, all strobes are ignored.
- cle  input  1  command latch enable.
- ale  input  1  address latch enable.
- we_n  input  1  write strobe; a low sample is one write transfer.
- re_n  input  1  read strobe; a low sample is one read transfer.
- wp_n  input  1  write protect, active low.
- dq_in  input  8  command/address/data from the controller.
- dq_out  output  8  read data.
- dq_oe  output  1  dq_out valid.
- rb_n  output  1  ready (1) / busy (0).

Behaviour:
- Reset: array is all 8'hFF, page register is 8'hFF, dq_out=0, dq_oe=0, rb_n=1, state IDLE, read mode = STATUS, fail flag = 0.
- Transfer decode, valid only when ce_n=0:
  - we_n=0 with cle=1, ale=0: command.
  - we_n=0 with ale=1, cle=0: address.
  - we_n=0 with cle=0, ale=0: data-in.
  - cle=ale=1, or we_n=re_n=0 together: ignored.
- Read transfer: re_n=0 and we_n=1. dq_out is registered and valid the cycle after the re_n sample, with dq_oe=1 in that cycle only.
- States:
  - IDLE
  - ADDR: collect address bytes.
  - DIN: program data.
  - BUSY: rb_n=0 with a down-counter.
  - DOUT
- Commands:
  - 8'h00: go to ADDR; expect column byte (low CW bits used) then row byte (low RW bits used, upper bits ignored).
  - 8'h30 after a complete 00 address: BUSY for TR_CYCLES, copy page into page register, then DOUT in page mode with pointer = column.
  - 8'h80: clear page register to 8'hFF; column byte, row byte, then DIN. Each data-in writes page_reg[ptr] and increments ptr.
  - 8'h10: BUSY for TPROG_CYCLES. At the final busy cycle, array page = array page AND page_reg (bits only clear).
  - 8'h60: one row byte; page bits ignored, block selected.
  - 8'hD0: BUSY for TERS_CYCLES, then all bytes of the block = 8'hFF.
  - 8'h90: one address byte (value ignored), then DOUT in ID mode. Bytes are ID_MAKER, ID_DEVICE, repeating.
  - 8'h70: DOUT in status mode. Status = {wp_n, ~busy, 5'b0, fail}.
  - 8'hFF: abort any operation without an array change; BUSY for TRST_CYCLES; fail=0; mode=STATUS.
- Protection: 8'h10 or 8'hD0 with wp_n=0 causes no array change, fail=1, no BUSY.
- fail clears on the next 8'h80, 8'h60 or 8'hFF.
- Busy counter loads N and rb_n=0 for exactly N cycles, starting the cycle after the confirm command. rb_n returns to 1 in the cycle the operation commits.
- During BUSY, only 8'h70 and 8'hFF are accepted. Other commands, addresses, data and page-mode reads are ignored. A status read still returns live status with bit6=0.
- Column pointer wraps PAGE_BYTES-1 → 0, for both DIN and page-mode DOUT.
- An unknown command, or a wrong confirm (e.g. 8'h10 after 8'h00), returns to IDLE with no array effect.
- After 8'h70, reads stay in status mode until 8'h00 re-entered with no address (read-mode return: page mode resumes at the current pointer).
- Async rst mid-BUSY: immediate return to reset values; the pending operation is discarded.

Test Plan:
- rst pulse, then read ID (90, addr 00, two reads) → dq_out 8'hEC, 8'hDA, each with dq_oe=1 one cycle after re_n low; rb_n=1.
- Program row 5 col 0 with bytes 8'hA5, 8'h3C, then 10 → rb_n=0 for exactly 20 cycles. Then 00/col0/row5/30 → rb_n low 8 cycles; reads give A5, 3C, FF.
- Reprogram row 5 col 0 with 8'h0F → readback 8'h05 (AND semantics).
- Erase block 1 (60, row 8'h04, D0) → rb_n low 40 cycles; rows 4..7 read all 8'hFF; row 8 untouched.
- wp_n=0, program row 2 → rb_n stays 1; status (70) reads 8'h41; row 2 unchanged.
- Program with col=15, writing 3 bytes 11, 22, 33 → bytes land at cols 15, 0, 1. During program busy, 70 → status 8'h80. 8'hFF mid-busy → rb_n low 4 cycles; page still 8'hFF.
